// File: rtl/ixc_assign_pkg.sv
// Shared types and helpers for the ixc_assign elastic pipe.
// Count-width function and a lane slice helper.
package ixc_assign_pkg;

  localparam int LANE_MAX = 64;
  localparam int VEC_MAX  = 1024;

  function automatic int cnt_w(input int depth);
    int b;
    b = $clog2(depth + 1);
    return (b < 1) ? 1 : b;
  endfunction

  function automatic logic [LANE_MAX-1:0] lane(
    input logic [VEC_MAX-1:0] vec,
    input int                 c,
    input int                 w
  );
    logic [LANE_MAX-1:0] r;
    r = '0;
    for (int i = 0; i < LANE_MAX; i++) begin
      if (i < w && (c * w + i) < VEC_MAX) begin
        r[i] = vec[c*w+i];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/ixc_assign_if.sv
// R/L valid-ready bundle for ixc_assign_pipe.
// master drives beats in and accepts out; slave is the pipe.
interface ixc_assign_if
  import ixc_assign_pkg::*;
#(
  parameter int WIDTH    = 10,
  parameter int CHANNELS = 1
);

  localparam int DW = WIDTH * CHANNELS;

  logic                R_valid;
  logic                R_ready;
  logic [DW-1:0]       R;
  logic [CHANNELS-1:0] R_mask;
  logic                L_valid;
  logic                L_ready;
  logic [DW-1:0]       L;

  modport master (
    output R_valid, R, R_mask, L_ready,
    input  R_ready, L_valid, L
  );

  modport slave (
    input  R_valid, R, R_mask, L_ready,
    output R_ready, L_valid, L
  );

endinterface

// File: rtl/ixc_assign_stage.sv
// One valid/data slot of the elastic pipe.
// in_adv: beat moves in; out_adv: held beat moves on.
module ixc_assign_stage
  import ixc_assign_pkg::*;
#(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_vld,
  input  logic [W-1:0] in_dat,
  input  logic         in_adv,
  input  logic         out_adv,
  output logic         vld,
  output logic [W-1:0] dat
);

  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= 1'b0;
      dat <= '0;
    end else if (in_adv) begin
      vld <= in_vld;
      dat <= in_dat;
    end else if (out_adv) begin
      vld <= 1'b0;
    end
  end

endmodule

// File: rtl/ixc_assign_pipe.sv
// Multi-channel masked assign through a DEPTH-stage
// valid/ready pipe; DEPTH=0 is a combinational bypass.
module ixc_assign_pipe
  import ixc_assign_pkg::*;
#(
  parameter int WIDTH    = 10,
  parameter int CHANNELS = 1,
  parameter int DEPTH    = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  ixc_assign_if.slave               bus,
  output logic [cnt_w(DEPTH)-1:0]   count
);

  localparam int DW = WIDTH * CHANNELS;
  localparam int CW = cnt_w(DEPTH);

  logic [DW-1:0] hold;
  logic [DW-1:0] merged;
  logic          accept;

  always_comb begin
    merged = hold;
    for (int c = 0; c < CHANNELS; c++) begin
      if (bus.R_mask[c]) begin
        merged[c*WIDTH +: WIDTH] = bus.R[c*WIDTH +: WIDTH];
      end
    end
  end

  // Only accepted beats refresh the held lanes.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold <= '0;
    end else if (accept) begin
      hold <= merged;
    end
  end

  if (DEPTH == 0) begin : g_bypass
    assign bus.L       = merged;
    assign bus.L_valid = bus.R_valid;
    assign bus.R_ready = bus.L_ready;
    assign accept      = bus.R_valid && bus.L_ready;
    assign count       = '0;
  end else begin : g_pipe
    logic [DEPTH-1:0] vld;
    logic [DEPTH-1:0] open;
    logic [DEPTH-1:0] in_adv;
    logic [DEPTH-1:0] out_adv;
    logic [DW-1:0]    dat [DEPTH];

    // Ready ripples back from L_ready in one pass.
    always_comb begin
      logic nxt;
      open    = '0;
      in_adv  = '0;
      out_adv = '0;
      nxt     = bus.L_ready;
      for (int i = DEPTH - 1; i >= 0; i--) begin
        out_adv[i] = vld[i] && nxt;
        open[i]    = !vld[i] || out_adv[i];
        nxt        = open[i];
      end
      in_adv[0] = bus.R_valid && open[0];
      for (int i = 1; i < DEPTH; i++) begin
        in_adv[i] = vld[i-1] && open[i];
      end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_stg
      logic          s_vld;
      logic [DW-1:0] s_dat;

      if (i == 0) begin : g_head
        assign s_vld = bus.R_valid;
        assign s_dat = merged;
      end else begin : g_body
        assign s_vld = vld[i-1];
        assign s_dat = dat[i-1];
      end

      ixc_assign_stage #(.W(DW)) u_stage (
        .clk     (clk),
        .rst     (rst),
        .in_vld  (s_vld),
        .in_dat  (s_dat),
        .in_adv  (in_adv[i]),
        .out_adv (out_adv[i]),
        .vld     (vld[i]),
        .dat     (dat[i])
      );
    end

    always_comb begin
      count = '0;
      for (int i = 0; i < DEPTH; i++) begin
        count = count + CW'(vld[i]);
      end
    end

    assign accept      = in_adv[0];
    assign bus.R_ready = open[0];
    assign bus.L_valid = vld[DEPTH-1];
    assign bus.L       = dat[DEPTH-1];
  end

endmodule

// File: tb/tb_ixc_assign_pipe.sv
// Bench for ixc_assign_pipe: queue reference model with ages,
// directed corner sequences and a DEPTH=0 vector table.
module tb_ixc_assign_pipe;
  import ixc_assign_pkg::*;

  localparam int W  = 10;
  localparam int C  = 2;
  localparam int D  = 2;
  localparam int DW = W * C;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ixc_assign_if #(.WIDTH(W), .CHANNELS(C)) ba ();
  ixc_assign_if #(.WIDTH(W), .CHANNELS(C)) bz ();

  logic [cnt_w(D)-1:0] cnt_a;
  logic [cnt_w(0)-1:0] cnt_z;

  ixc_assign_pipe #(.WIDTH(W), .CHANNELS(C), .DEPTH(D)) dut_a (
    .clk   (clk),
    .rst   (rst),
    .bus   (ba),
    .count (cnt_a)
  );

  ixc_assign_pipe #(.WIDTH(W), .CHANNELS(C), .DEPTH(0)) dut_z (
    .clk   (clk),
    .rst   (rst),
    .bus   (bz),
    .count (cnt_z)
  );

  typedef struct {
    logic [DW-1:0] d;
    int            age;
  } beat_t;

  typedef struct {
    logic          rv;
    logic [DW-1:0] r;
    logic [C-1:0]  m;
    logic          lr;
    logic [DW-1:0] el;
    logic          elv;
    logic          err;
  } vec_t;

  beat_t         q[$];
  logic [DW-1:0] hold_m;
  logic [DW-1:0] got[$];
  int            got_cyc[$];
  int            cnt_hist[$];
  int            cyc;
  int            n_tests;
  int            n_fail;

  logic          s_rr, s_lv;
  logic [DW-1:0] s_l;
  int            s_cnt;

  vec_t          tbl[7];
  logic [DW-1:0] tx[$];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] pk(input logic [9:0] hi,
                                       input logic [9:0] lo);
    return {hi, lo};
  endfunction

  function automatic logic [DW-1:0] merge_ref(input logic [DW-1:0] r,
                                              input logic [C-1:0] m,
                                              input logic [DW-1:0] h);
    logic [DW-1:0]       o;
    logic [LANE_MAX-1:0] x;
    o = '0;
    for (int c = 0; c < C; c++) begin
      x = m[c] ? lane(VEC_MAX'(r), c, W) : lane(VEC_MAX'(h), c, W);
      o[c*W +: W] = x[W-1:0];
    end
    return o;
  endfunction

  task automatic drv(input logic v, input logic [DW-1:0] r,
                     input logic [C-1:0] m, input logic lr);
    ba.R_valid = v;
    ba.R       = r;
    ba.R_mask  = m;
    ba.L_ready = lr;
  endtask

  // One cycle: compare at negedge, then advance the model at posedge.
  task automatic step();
    logic          lv, rr, acc, del;
    logic [DW-1:0] mg;
    @(negedge clk);
    lv = (q.size() > 0) && (q[0].age >= D);
    rr = (q.size() < D) || ba.L_ready;
    s_rr  = ba.R_ready;
    s_lv  = ba.L_valid;
    s_l   = ba.L;
    s_cnt = int'(cnt_a);
    cnt_hist.push_back(s_cnt);
    chk("count", 32'(cnt_a), 32'(q.size()));
    chk("l_valid", 32'(ba.L_valid), 32'(lv));
    chk("r_ready", 32'(ba.R_ready), 32'(rr));
    if (lv) chk("l_data", 32'(ba.L), 32'(q[0].d));
    acc = ba.R_valid && rr;
    del = lv && ba.L_ready;
    mg  = merge_ref(ba.R, ba.R_mask, hold_m);
    @(posedge clk);
    if (rst) begin
      q.delete();
      hold_m = '0;
    end else begin
      if (del) begin
        got.push_back(s_l);
        got_cyc.push_back(cyc);
        void'(q.pop_front());
      end
      foreach (q[i]) q[i].age++;
      if (acc) begin
        q.push_back('{mg, 1});
        hold_m = mg;
      end
    end
    cyc++;
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int s0;
    n_tests = 0;
    n_fail  = 0;
    cyc     = 0;
    hold_m  = '0;

    tbl[0] = '{1'b0, pk(10'h3FF, 10'h3FF), 2'b00, 1'b0,
               pk(10'h000, 10'h000), 1'b0, 1'b0};
    tbl[1] = '{1'b1, pk(10'h0AB, 10'h0CD), 2'b11, 1'b1,
               pk(10'h0AB, 10'h0CD), 1'b1, 1'b1};
    tbl[2] = '{1'b1, pk(10'h3FF, 10'h001), 2'b01, 1'b0,
               pk(10'h0AB, 10'h001), 1'b1, 1'b0};
    tbl[3] = '{1'b1, pk(10'h155, 10'h2AA), 2'b00, 1'b1,
               pk(10'h0AB, 10'h0CD), 1'b1, 1'b1};
    tbl[4] = '{1'b0, pk(10'h200, 10'h100), 2'b10, 1'b1,
               pk(10'h200, 10'h0CD), 1'b0, 1'b1};
    tbl[5] = '{1'b1, pk(10'h200, 10'h100), 2'b10, 1'b1,
               pk(10'h200, 10'h0CD), 1'b1, 1'b1};
    tbl[6] = '{1'b1, pk(10'h000, 10'h000), 2'b00, 1'b0,
               pk(10'h200, 10'h0CD), 1'b1, 1'b0};

    drv(1'b0, '0, '0, 1'b0);
    bz.R_valid = 1'b0;
    bz.R       = '0;
    bz.R_mask  = '0;
    bz.L_ready = 1'b0;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("rst_l_valid", 32'(ba.L_valid), 32'd0);
    chk("rst_l", 32'(ba.L), 32'd0);
    chk("rst_count", 32'(cnt_a), 32'd0);
    chk("rst_r_ready", 32'(ba.R_ready), 32'd1);
    @(posedge clk);
    #1;

    for (int i = 0; i < 7; i++) begin
      bz.R_valid = tbl[i].rv;
      bz.R       = tbl[i].r;
      bz.R_mask  = tbl[i].m;
      bz.L_ready = tbl[i].lr;
      #1;
      chk($sformatf("d0_l[%0d]", i), 32'(bz.L), 32'(tbl[i].el));
      chk($sformatf("d0_lv[%0d]", i), 32'(bz.L_valid), 32'(tbl[i].elv));
      chk($sformatf("d0_rr[%0d]", i), 32'(bz.R_ready), 32'(tbl[i].err));
      chk($sformatf("d0_cnt[%0d]", i), 32'(cnt_z), 32'd0);
      @(posedge clk);
      #1;
    end
    bz.R_valid = 1'b0;

    // Streaming at full rate
    got.delete();
    got_cyc.delete();
    s0 = cyc;
    drv(1'b1, pk(10'h001, 10'h002), 2'b11, 1'b1); step();
    drv(1'b1, pk(10'h003, 10'h004), 2'b11, 1'b1); step();
    drv(1'b1, pk(10'h005, 10'h006), 2'b11, 1'b1); step();
    drv(1'b0, '0, 2'b00, 1'b1);
    repeat (4) step();
    chk("stream_n", 32'(got.size()), 32'd3);
    if (got.size() == 3) begin
      chk("stream_0", 32'(got[0]), 32'(pk(10'h001, 10'h002)));
      chk("stream_1", 32'(got[1]), 32'(pk(10'h003, 10'h004)));
      chk("stream_2", 32'(got[2]), 32'(pk(10'h005, 10'h006)));
      for (int k = 0; k < 3; k++)
        chk($sformatf("stream_cyc%0d", k), 32'(got_cyc[k]), 32'(s0 + 2 + k));
    end
    chk("stream_cnt2", 32'(cnt_hist[s0+2]), 32'd2);
    chk("stream_cnt3", 32'(cnt_hist[s0+3]), 32'd2);

    // Mask hold
    got.delete();
    drv(1'b1, pk(10'h0AA, 10'h0BB), 2'b11, 1'b1); step();
    drv(1'b1, pk(10'h3FF, 10'h111), 2'b01, 1'b1); step();
    drv(1'b0, '0, 2'b00, 1'b1);
    repeat (4) step();
    chk("mask_n", 32'(got.size()), 32'd2);
    if (got.size() == 2) begin
      chk("mask_0", 32'(got[0]), 32'(pk(10'h0AA, 10'h0BB)));
      chk("mask_1", 32'(got[1]), 32'(pk(10'h0AA, 10'h111)));
    end

    // Back-pressure
    got.delete();
    for (int k = 0; k < 5; k++)
      tx.push_back(pk(10'(10'h100 + k), 10'(10'h200 + k)));
    for (int cy = 0; cy < 20 && (tx.size() > 0 || q.size() > 0); cy++) begin
      logic a;
      drv(tx.size() > 0, (tx.size() > 0) ? tx[0] : '0, 2'b11, cy >= 5);
      a = (tx.size() > 0) && ((q.size() < D) || (cy >= 5));
      step();
      if (cy >= 2 && cy <= 4) begin
        chk($sformatf("bp_rr%0d", cy), 32'(s_rr), 32'd0);
        chk($sformatf("bp_cnt%0d", cy), 32'(s_cnt), 32'd2);
        chk($sformatf("bp_l%0d", cy), 32'(s_l), 32'(pk(10'h100, 10'h200)));
      end
      if (cy == 5) chk("bp_rr_rise", 32'(s_rr), 32'd1);
      if (a) void'(tx.pop_front());
    end
    chk("bp_n", 32'(got.size()), 32'd5);
    for (int k = 0; k < 5 && k < got.size(); k++)
      chk($sformatf("bp_ord%0d", k), 32'(got[k]),
          32'(pk(10'(10'h100 + k), 10'(10'h200 + k))));
    tx.delete();

    // Rejected beat must not reach hold
    got.delete();
    drv(1'b1, pk(10'h011, 10'h022), 2'b11, 1'b0); step();
    drv(1'b1, pk(10'h033, 10'h044), 2'b11, 1'b0); step();
    drv(1'b1, pk(10'h3FF, 10'h155), 2'b11, 1'b0); step();
    chk("rej_rr", 32'(s_rr), 32'd0);
    drv(1'b1, pk(10'h3FF, 10'h155), 2'b00, 1'b1); step();
    chk("rej_acc", 32'(s_rr), 32'd1);
    drv(1'b0, '0, 2'b00, 1'b1);
    repeat (4) step();
    chk("rej_n", 32'(got.size()), 32'd3);
    if (got.size() == 3)
      chk("rej_hold", 32'(got[2]), 32'(pk(10'h033, 10'h044)));

    // Reset mid-flight
    got.delete();
    drv(1'b1, pk(10'h123, 10'h321), 2'b11, 1'b0); step(); step();
    drv(1'b0, '0, 2'b00, 1'b0); step();
    chk("mid_cnt", 32'(s_cnt), 32'd2);
    rst = 1'b1; step(); rst = 1'b0;
    step();
    chk("mid_lv", 32'(s_lv), 32'd0);
    chk("mid_l", 32'(s_l), 32'd0);
    chk("mid_cnt0", 32'(s_cnt), 32'd0);
    chk("mid_rr", 32'(s_rr), 32'd1);
    drv(1'b1, pk(10'h3FF, 10'h3FF), 2'b00, 1'b1); step();
    drv(1'b0, '0, 2'b00, 1'b1);
    repeat (3) step();
    chk("mid_n", 32'(got.size()), 32'd1);
    if (got.size() == 1) chk("mid_zero", 32'(got[0]), 32'd0);

    // Random traffic against the queue model
    repeat (400) begin
      rst = ($urandom_range(0, 63) == 0);
      drv(1'($urandom_range(0, 1)), DW'($urandom), C'($urandom),
          $urandom_range(0, 3) != 0);
      step();
    end
    rst = 1'b0;
    drv(1'b0, '0, 2'b00, 1'b1);
    repeat (4) step();
    chk("rand_drain", 32'(q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
